uart_frame_receiver: RTL and testbench

Parametrised UART receive path replacing the fixed 8N1 receiver. It synchronises the line, qualifies the start bit, and majority-samples every bit at mid-period. Frame format (5–9 data bits, none/odd/even parity, 1–2 stop bits) is set by parameters. Received words and per-word error flags are buffered in a small show-ahead FIFO behind a valid/ready handshake, so the core-side consumer may stall without losing back-to-back frames.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_rx_fifo.sv | 62 ++++++
 rtl/uart_frame_receiver.sv | 164 ++++++++++++++++
 tb/tb_uart_frame_receiver.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types: parity-mode constants, receiver FSM states and the
// receive-buffer entry layout.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Entries carry the widest supported word; narrower frames zero-extend.
    localparam int RX_MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    typedef struct packed {
        logic [RX_MAX_DATA_BITS-1:0] data;
        logic                        parity_err;
        logic                        frame_err;
    } rx_entry_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead synchronous FIFO of rx_entry_t; the head entry is always visible
// on rd_entry and the next one appears the cycle after a pop.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  rx_entry_t                wr_entry,
    input  logic                     pop,
    output rx_entry_t                rd_entry,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    rx_entry_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     cnt;
    logic            do_push;
    logic            do_pop;

    assign full  = (cnt == (AW+1)'(DEPTH));
    assign empty = (cnt == '0);

    // A pop frees the slot a simultaneous push needs, so full+pop still writes.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_entry;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign rd_entry = mem[rd_ptr];
    assign count    = cnt;

endmodule

// File: rtl/uart_frame_receiver.sv
// Parametrised UART receiver: line synchroniser, start qualification,
// 3-point majority bit sampling and a show-ahead receive FIFO.
module uart_frame_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10000,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          uart_rx,
    // Handshake: an entry transfers on every clock edge where valid && ready;
    // data/flags are stable while valid is high and ready is low.
    output logic [DATA_BITS-1:0]          data,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          valid,
    input  logic                          ready,
    output logic                          overrun,
    output logic                          waiting,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int              PW         = $clog2(CLKS_PER_BIT);
    localparam int              H          = CLKS_PER_BIT / 2;
    localparam logic [PW-1:0]   PH_A       = PW'(H - 1);
    localparam logic [PW-1:0]   PH_B       = PW'(H);
    localparam logic [PW-1:0]   PH_C       = PW'(H + 1);
    localparam logic [PW-1:0]   PH_LAST    = PW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]      LAST_DATA  = 4'(DATA_BITS - 1);
    localparam logic [3:0]      LAST_STOP  = 4'(STOP_BITS - 1);
    localparam logic            ODD_EXPECT = (PARITY == PARITY_ODD);

    logic                 rx_meta;
    logic                 rx_s;
    rx_state_t            state;
    rx_state_t            state_n;
    logic [PW-1:0]        phase;
    logic                 samp_a;
    logic                 samp_b;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 par_err_q;
    logic                 ferr_q;
    logic                 push_q;
    logic                 counting;
    logic                 sample_pt;
    logic                 maj;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    rx_entry_t            push_entry;
    rx_entry_t            head;
    logic                 unused_head_bits;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
        end
    end

    assign counting  = (state == RX_START) || (state == RX_DATA) ||
                       (state == RX_PARITY) || (state == RX_STOP);
    assign sample_pt = counting && (phase == PH_C);
    assign maj       = majority3(samp_a, samp_b, rx_s);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RX_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            RX_IDLE:   if (!rx_s) state_n = RX_START;
            RX_START:  if (sample_pt) state_n = maj ? RX_IDLE : RX_DATA;
            RX_DATA:   if (sample_pt && bit_cnt == LAST_DATA)
                           state_n = (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
            RX_PARITY: if (sample_pt) state_n = RX_STOP;
            // A low final stop bit means the line may be held in break.
            RX_STOP:   if (sample_pt && bit_cnt == LAST_STOP)
                           state_n = maj ? RX_IDLE : RX_BREAK;
            RX_BREAK:  if (rx_s) state_n = RX_IDLE;
            default:   state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase     <= '0;
            samp_a    <= 1'b1;
            samp_b    <= 1'b1;
            bit_cnt   <= '0;
            shift     <= '0;
            par_err_q <= 1'b0;
            ferr_q    <= 1'b0;
            push_q    <= 1'b0;
        end else begin
            if (!counting || phase == PH_LAST) begin
                phase <= '0;
            end else begin
                phase <= phase + PW'(1);
            end
            if (phase == PH_A) samp_a <= rx_s;
            if (phase == PH_B) samp_b <= rx_s;
            push_q <= 1'b0;
            if (sample_pt) begin
                bit_cnt <= (state_n != state) ? 4'd0 : bit_cnt + 4'd1;
                case (state)
                    RX_START: begin
                        par_err_q <= 1'b0;
                        ferr_q    <= 1'b0;
                    end
                    RX_DATA:   shift     <= {maj, shift[DATA_BITS-1:1]};
                    RX_PARITY: par_err_q <= ((^shift) ^ maj) != ODD_EXPECT;
                    RX_STOP: begin
                        if (!maj) ferr_q <= 1'b1;
                        if (bit_cnt == LAST_STOP) push_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign push_entry = '{data:       RX_MAX_DATA_BITS'(shift),
                          parity_err: par_err_q,
                          frame_err:  ferr_q};

    assign pop = valid && ready;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push_q),
        .wr_entry (push_entry),
        .pop      (pop),
        .rd_entry (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (count)
    );

    assign valid            = !fifo_empty;
    assign data             = head.data[DATA_BITS-1:0];
    assign parity_err       = head.parity_err;
    assign frame_err        = head.frame_err;
    assign overrun          = push_q && fifo_full && !pop;
    assign waiting          = (state == RX_IDLE);
    assign unused_head_bits = ^head.data;

endmodule

// File: tb/tb_uart_frame_receiver.sv
// Randomised scoreboard bench for uart_frame_receiver: an 8N1 instance and a
// 7E2 instance, each with its own expected queue and output monitor.
module tb_uart_frame_receiver;

  localparam int CPB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       rx;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       perr, ferr, valid, ovr, waiting;
  logic [2:0] count;

  logic       rx2;
  logic       ready2 = 1'b1;
  logic [6:0] data2;
  logic       perr2, ferr2, valid2, ovr2, waiting2;
  logic [2:0] count2;

  int total = 0;
  int bad = 0;
  int ovr_seen = 0;
  int ovr2_seen = 0;
  int ovr_base;
  int ready_mode = 0;

  logic [10:0] exp_q[$];
  logic [10:0] exp2_q[$];
  logic [10:0] e_main, e_ext;

  uart_frame_receiver #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .uart_rx(rx), .data(data), .parity_err(perr),
    .frame_err(ferr), .valid(valid), .ready(ready), .overrun(ovr),
    .waiting(waiting), .count(count)
  );

  uart_frame_receiver #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) dut_e (
    .clk(clk), .reset(reset), .uart_rx(rx2), .data(data2), .parity_err(perr2),
    .frame_err(ferr2), .valid(valid2), .ready(ready2), .overrun(ovr2),
    .waiting(waiting2), .count(count2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected entry {frame_err, parity_err, data} from the frame as sent.
  function automatic logic [10:0] model_entry(input logic [8:0] d, input int mode,
                                              input logic pb, input logic stops_ok);
    int ones;
    logic pe;
    ones = $countones(d) + int'(pb);
    case (mode)
      1:       pe = (ones % 2) == 0;
      2:       pe = (ones % 2) == 1;
      default: pe = 1'b0;
    endcase
    return {~stops_ok, pe, d};
  endfunction

  // ready driver: 0 = low, 1 = high, 2 = random each cycle
  initial forever begin
    @(posedge clk);
    #2;
    if (ready_mode == 2) ready = 1'($urandom_range(0, 1));
    else ready = (ready_mode == 1);
  end

  task automatic drive_bits(input bit which, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (which) rx2 = bits[i];
      else rx = bits[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    rx2 = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send8(input logic [7:0] d, input logic stop, input bit expect_it);
    if (expect_it) exp_q.push_back(model_entry({1'b0, d}, 0, 1'b0, stop));
    drive_bits(1'b0, {6'b0, stop, d, 1'b0}, 10);
  endtask

  task automatic send7e(input logic [6:0] d, input logic flip, input logic s1, input logic s2);
    logic pb;
    pb = (^d) ^ flip;
    exp2_q.push_back(model_entry({2'b0, d}, 2, pb, s1 & s2));
    drive_bits(1'b1, {5'b0, s2, s1, pb, d, 1'b0}, 11);
  endtask

  task automatic drain_main();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_main_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic drain_ext();
    int n;
    n = 0;
    while (exp2_q.size() > 0 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_ext_empty", 32'(exp2_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (reset && valid && ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL main_unexpected_word: got=%0h expected none at %0t", data, $time);
      end else begin
        e_main = exp_q.pop_front();
        check("main_data", 32'(data), 32'(e_main[8:0]));
        check("main_parity_err", 32'(perr), 32'(e_main[9]));
        check("main_frame_err", 32'(ferr), 32'(e_main[10]));
      end
    end
    if (reset && ovr) ovr_seen++;
  end

  always @(negedge clk) begin
    if (reset && valid2 && ready2) begin
      if (exp2_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL ext_unexpected_word: got=%0h expected none at %0t", data2, $time);
      end else begin
        e_ext = exp2_q.pop_front();
        check("ext_data", 32'(data2), 32'(e_ext[8:0]));
        check("ext_parity_err", 32'(perr2), 32'(e_ext[9]));
        check("ext_frame_err", 32'(ferr2), 32'(e_ext[10]));
      end
    end
    if (reset && ovr2) ovr2_seen++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    rx = 1'b1;
    rx2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_overrun", 32'(ovr), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_parity_err", 32'(perr), 32'd0);
    check("rst_frame_err", 32'(ferr), 32'd0);
    check("rst_waiting", 32'(waiting), 32'd1);
    check("rst_ext_valid", 32'(valid2), 32'd0);
    check("rst_ext_waiting", 32'(waiting2), 32'd1);
    reset = 1'b1;
    idle(10);

    // back-to-back 8N1 frames; valid rises the cycle after the push cycle
    ready_mode = 1;
    idle(2);
    fork
      begin
        send8(8'hA5, 1'b1, 1'b1);
        send8(8'h3C, 1'b1, 1'b1);
      end
      begin
        repeat (157) @(posedge clk);
        #2;
        check("t1_valid_in_push_cycle", 32'(valid), 32'd0);
        @(posedge clk);
        #2;
        check("t1_valid_after_push", 32'(valid), 32'd1);
      end
    join
    idle(20);
    drain_main();
    check("t1_waiting", 32'(waiting), 32'd1);

    // 5-cycle low glitch
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("t3_start_entered", 32'(waiting), 32'd0);
    @(posedge clk);
    #1;
    rx = 1'b1;
    idle(20);
    check("t3_waiting_again", 32'(waiting), 32'd1);
    check("t3_no_push", 32'(count), 32'd0);

    // stop bit low, line held low for 3 bit periods
    send8(8'h96, 1'b0, 1'b1);
    repeat (3 * CPB) @(posedge clk);
    #1;
    check("t4_break_held", 32'(waiting), 32'd0);
    idle(8);
    check("t4_break_released", 32'(waiting), 32'd1);
    drain_main();
    check("t4_single_entry", 32'(count), 32'd0);

    // overflow with ready low
    ready_mode = 0;
    idle(4);
    ovr_base = ovr_seen;
    for (int i = 1; i <= 4; i++) send8(8'(i), 1'b1, 1'b1);
    send8(8'h05, 1'b1, 1'b0);
    idle(10);
    check("t5_count_full", 32'(count), 32'd4);
    check("t5_overrun_pulses", 32'(ovr_seen - ovr_base), 32'd1);
    ready_mode = 1;
    drain_main();

    // pop coinciding with the push on a full FIFO
    ready_mode = 0;
    idle(4);
    ovr_base = ovr_seen;
    for (int i = 1; i <= 4; i++) send8(8'(i), 1'b1, 1'b1);
    fork
      send8(8'h05, 1'b1, 1'b1);
      begin
        repeat (157) @(posedge clk);
        #1;
        ready_mode = 1;
        @(posedge clk);
        #1;
        ready_mode = 0;
      end
    join
    idle(10);
    check("t5b_count", 32'(count), 32'd4);
    check("t5b_no_overrun", 32'(ovr_seen - ovr_base), 32'd0);
    ready_mode = 1;
    drain_main();

    // asynchronous reset mid data bit 3 with two stored entries
    ready_mode = 0;
    idle(4);
    send8(8'h11, 1'b1, 1'b1);
    send8(8'h22, 1'b1, 1'b1);
    drive_bits(1'b0, 16'h000A, 4);
    rx = 1'b1;
    repeat (CPB / 2) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("t6_valid_cleared", 32'(valid), 32'd0);
    check("t6_count_cleared", 32'(count), 32'd0);
    check("t6_waiting", 32'(waiting), 32'd1);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    idle(5);
    ready_mode = 1;
    send8(8'h5A, 1'b1, 1'b1);
    idle(5);
    drain_main();

    // random 8N1 traffic with random consumer stalls
    ready_mode = 2;
    for (int i = 0; i < 12; i++) begin
      send8(8'($urandom_range(0, 255)), 1'b1, 1'b1);
      idle($urandom_range(0, 8));
    end
    ready_mode = 1;
    idle(4);
    drain_main();

    // 7E2: correct parity then flipped parity
    send7e(7'h41, 1'b0, 1'b1, 1'b1);
    send7e(7'h41, 1'b1, 1'b1, 1'b1);
    idle(4);
    drain_ext();

    // random 7E2 traffic with occasional parity and stop errors
    for (int i = 0; i < 10; i++) begin
      logic s1, s2;
      s1 = ($urandom_range(0, 4) != 0);
      s2 = ($urandom_range(0, 4) != 0);
      send7e(7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), s1, s2);
      idle(s2 ? $urandom_range(0, 6) : 4);
    end
    idle(8);
    drain_ext();

    check("main_queue_left", 32'(exp_q.size()), 32'd0);
    check("ext_no_overrun", 32'(ovr2_seen), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
